// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - shared encodings for the LEGv8 control sequencer
//
// Purpose: state and instruction-class encodings plus the illegal opcode
// pattern, shared by the sequencer and its class encoder.
// Ports: none (package).
package legv8_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IF   = 2'd0,
    ST_EX   = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    IC_DATA_IMM = 2'd0,
    IC_BRANCH   = 2'd1,
    IC_MEM      = 2'd2,
    IC_DATA_REG = 2'd3
  } iclass_e;

  // imem_rdata[28:26] value that marks an unallocated encoding.
  localparam logic [2:0] ILLEGAL_OP = 3'b000;

endpackage

// File: rtl/legv8_iclass_encoder.sv
// rtl/legv8_iclass_encoder.sv - combinational instruction-class decoder
//
// Purpose: maps instruction bits [28:25] to the 2-bit execution class.
// Ports:
//   ir_field  in  4  instruction bits [28:25] (ir_field[0] = bit 25)
//   iclass    out 2  DataImm / Branch / Mem / DataReg
module legv8_iclass_encoder
  import legv8_ctrl_pkg::*;
(
  input  logic [3:0] ir_field,
  output iclass_e    iclass
);

  logic b27, b26, b25;
  // Bit 28 belongs to the decoded field but does not affect the class.
  logic unused_b28;

  assign unused_b28 = ir_field[3];
  assign b27 = ir_field[2];
  assign b26 = ir_field[1];
  assign b25 = ir_field[0];

  assign iclass = iclass_e'({b27, (~b27 & b26) | (b27 & b25)});

endmodule

// File: rtl/legv8_ctrl_sequencer.sv
// rtl/legv8_ctrl_sequencer.sv - multi-cycle fetch/execute control sequencer
//
// Purpose: fetches an instruction over a req/ack handshake, latches it,
// runs a class-dependent number of execute steps and stalls on data memory
// for the Mem class.
// Ports:
//   clock, reset (async, active-low), run
//   imem_req/imem_ack/imem_rdata  instruction fetch handshake
//   dmem_req/dmem_ack             data memory handshake (Mem class)
//   ir, iclass, state, ex_step, ex_last   registered status
//   ir_load, pc_inc               fetch handshake pulses
//   illegal                       sticky unallocated-encoding flag
module legv8_ctrl_sequencer
  import legv8_ctrl_pkg::*;
#(
  parameter int MAX_EX     = 4,
  parameter int EX_LEN_IMM = 1,
  parameter int EX_LEN_BR  = 1,
  parameter int EX_LEN_MEM = 2,
  parameter int EX_LEN_REG = 1,
  localparam int STEP_W    = (MAX_EX > 1) ? $clog2(MAX_EX) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  input  logic              dmem_ack,
  output logic [31:0]       ir,
  output logic [1:0]        iclass,
  output logic [1:0]        state,
  output logic [STEP_W-1:0] ex_step,
  output logic              ex_last,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              illegal
);

  // Final step index per class; lengths are fixed at elaboration.
  localparam logic [STEP_W-1:0] LAST_IMM = STEP_W'(EX_LEN_IMM - 1);
  localparam logic [STEP_W-1:0] LAST_BR  = STEP_W'(EX_LEN_BR - 1);
  localparam logic [STEP_W-1:0] LAST_MEM = STEP_W'(EX_LEN_MEM - 1);
  localparam logic [STEP_W-1:0] LAST_REG = STEP_W'(EX_LEN_REG - 1);

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [STEP_W-1:0] ex_step_q, ex_step_d;
  logic              illegal_q, illegal_d;
  // A fetch request was raised and not yet accepted; holds imem_req up.
  logic              pend_q, pend_d;
  // Clear during reset and until the first edge after release, so that no
  // request can appear combinationally off run while reset is releasing.
  logic              armed_q, armed_d;

  iclass_e           cls;
  logic [STEP_W-1:0] last_step;
  logic              at_last;
  logic              fetch_hs;

  legv8_iclass_encoder u_iclass_encoder (
    .ir_field (ir_q[28:25]),
    .iclass   (cls)
  );

  always_comb begin
    last_step = LAST_IMM;
    case (cls)
      IC_DATA_IMM: last_step = LAST_IMM;
      IC_BRANCH:   last_step = LAST_BR;
      IC_MEM:      last_step = LAST_MEM;
      IC_DATA_REG: last_step = LAST_REG;
      default:     last_step = LAST_IMM;
    endcase
  end

  assign at_last = (ex_step_q == last_step);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ex_step_d = ex_step_q;
    illegal_d = illegal_q;
    pend_d    = pend_q;
    armed_d   = 1'b1;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ex_last   = 1'b0;
    fetch_hs  = 1'b0;

    case (state_q)
      ST_IF: begin
        imem_req = armed_q & (run | pend_q);
        fetch_hs = imem_req & imem_ack;
        pend_d   = imem_req & ~imem_ack;
        if (fetch_hs) begin
          ir_d = imem_rdata;
          if (imem_rdata[28:26] == ILLEGAL_OP) begin
            // Unallocated encoding: flag it and go straight back to fetch.
            illegal_d = 1'b1;
          end else begin
            state_d   = ST_EX;
            ex_step_d = '0;
          end
        end
      end

      ST_EX: begin
        ex_last = at_last;
        if (at_last) begin
          if (cls == IC_MEM) begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
              state_d   = ST_IF;
              ex_step_d = '0;
            end else begin
              // ex_step stays at the final index for the whole stall.
              state_d = ST_WAIT;
            end
          end else begin
            state_d   = ST_IF;
            ex_step_d = '0;
          end
        end else begin
          ex_step_d = ex_step_q + 1'b1;
        end
      end

      ST_WAIT: begin
        dmem_req = 1'b1;
        ex_last  = 1'b1;
        if (dmem_ack) begin
          state_d   = ST_IF;
          ex_step_d = '0;
        end
      end

      default: begin
        state_d   = ST_IF;
        ex_step_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IF;
      ir_q      <= '0;
      ex_step_q <= '0;
      illegal_q <= 1'b0;
      pend_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ex_step_q <= ex_step_d;
      illegal_q <= illegal_d;
      pend_q    <= pend_d;
      armed_q   <= armed_d;
    end
  end

  assign ir      = ir_q;
  assign iclass  = cls;
  assign state   = state_q;
  assign ex_step = ex_step_q;
  assign ir_load = fetch_hs;
  assign pc_inc  = fetch_hs;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_legv8_ctrl_sequencer.sv
// tb/tb_legv8_ctrl_sequencer.sv - self-checking bench for legv8_ctrl_sequencer
module tb_legv8_ctrl_sequencer;

  localparam logic [31:0] I_ADDI = 32'h9100_0421;
  localparam logic [31:0] I_LDUR = 32'hF840_0020;
  localparam logic [31:0] I_ADD  = 32'h8B02_0020;
  localparam logic [31:0] I_B    = 32'h1400_0003;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_ack;
  logic [31:0] ir;
  logic [1:0]  iclass;
  logic [1:0]  state;
  logic [2:0]  ex_step;
  logic        ex_last;
  logic        ir_load;
  logic        pc_inc;
  logic        illegal;

  legv8_ctrl_sequencer #(
    .MAX_EX     (8),
    .EX_LEN_REG (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .ir         (ir),
    .iclass     (iclass),
    .state      (state),
    .ex_step    (ex_step),
    .ex_last    (ex_last),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .illegal    (illegal)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 fetch, 1 execute, 2 memory wait.
  int          m_phase, m_step, m_ill, m_pend, m_armed;
  logic [31:0] m_ir;

  function automatic int cls_of(input logic [31:0] i);
    int b27, b26, b25;
    b27 = i[27]; b26 = i[26]; b25 = i[25];
    return b27 * 2 + (b27 ? b25 : b26);
  endfunction

  function automatic int len_of(input int c);
    case (c)
      0: return 1;
      1: return 1;
      2: return 2;
      default: return 8;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_step = 0; m_ill = 0; m_pend = 0; m_armed = 0; m_ir = '0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare everything
  // against the model, then advance the model past the next rising edge.
  task automatic do_cycle(input logic r, input logic rn, input logic ia,
                          input logic [31:0] rd, input logic da);
    int c, len, e_req, e_hs, e_last, e_dreq;
    @(negedge clock);
    reset = r; run = rn; imem_ack = ia; imem_rdata = rd; dmem_ack = da;
    #1;
    if (!r) model_reset();
    c      = cls_of(m_ir);
    len    = len_of(c);
    e_req  = (m_armed != 0 && m_phase == 0 && (rn || m_pend != 0)) ? 1 : 0;
    e_hs   = (e_req != 0 && ia) ? 1 : 0;
    e_last = (m_phase != 0 && m_step == len - 1) ? 1 : 0;
    e_dreq = (m_phase == 2 || (m_phase == 1 && c == 2 && m_step == len - 1)) ? 1 : 0;
    chk("state", state, m_phase);
    chk("ex_step", ex_step, m_step);
    chk("ex_last", ex_last, e_last);
    chk("imem_req", imem_req, e_req);
    chk("dmem_req", dmem_req, e_dreq);
    chk("ir_load", ir_load, e_hs);
    chk("pc_inc", pc_inc, e_hs);
    chk("ir", ir, m_ir);
    chk("iclass", iclass, c);
    chk("illegal", illegal, m_ill);
    if (r) begin
      m_armed = 1;
      case (m_phase)
        0: begin
          m_pend = (e_req != 0 && !ia) ? 1 : 0;
          if (e_hs != 0) begin
            m_ir = rd;
            if (rd[28:26] == 3'b000) m_ill = 1;
            else begin m_phase = 1; m_step = 0; end
          end
        end
        1: begin
          if (m_step == len - 1) begin
            if (c == 2 && !da) m_phase = 2;
            else begin m_phase = 0; m_step = 0; end
          end else m_step++;
        end
        default: if (da) begin m_phase = 0; m_step = 0; end
      endcase
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0;
    model_reset();

    // Reset state, then first request only after the first edge post-release.
    do_cycle(0, 1, 1, I_ADDI, 0);
    chk("rst_state", state, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_ir", ir, 0);
    do_cycle(1, 1, 1, I_ADDI, 0);
    chk("first_req_late", imem_req, 0);

    // DataImm back-to-back: IF, EX0, IF, EX0.
    for (int k = 0; k < 4; k++) begin
      do_cycle(1, 1, 1, I_ADDI, 0);
      chk("addi_state", state, k % 2);
      chk("addi_load", ir_load, (k % 2 == 0) ? 1 : 0);
    end
    chk("addi_class", iclass, 0);

    // LDUR with three stall cycles.
    for (int k = 0; k < 7; k++) begin
      logic [1:0] seq [7];
      seq = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
      do_cycle(1, (k == 0), 1, I_LDUR, (k == 5));
      chk("ldur_state", state, seq[k]);
      if (k == 2) chk("ldur_dreq", dmem_req, 1);
      if (k >= 3 && k <= 5) chk("ldur_wait_step", ex_step, 1);
    end

    // Delayed imem_ack with run dropped: request held, single load.
    for (int k = 0; k < 5; k++) begin
      do_cycle(1, (k == 0), (k == 4), (k == 4) ? I_ADD : 32'hDEAD_BEEF, 0);
      chk("hold_req", imem_req, 1);
      chk("hold_load", ir_load, (k == 4) ? 1 : 0);
    end
    // ADD with EX length 8.
    for (int k = 0; k < 8; k++) begin
      do_cycle(1, 0, 0, 32'h0, 0);
      chk("add_state", state, 1);
      chk("add_step", ex_step, k);
      chk("add_last", ex_last, (k == 7) ? 1 : 0);
    end
    chk("add_ir", ir, I_ADD);

    // Illegal encoding: no EX, flag sticks, next fetch proceeds.
    do_cycle(1, 1, 1, 32'h0, 0);
    do_cycle(1, 1, 1, I_ADDI, 0);
    chk("ill_state", state, 0);
    chk("ill_flag", illegal, 1);
    chk("ill_refetch", ir_load, 1);
    do_cycle(1, 0, 0, 32'h0, 0);
    chk("ill_ex", state, 1);
    chk("ill_sticky", illegal, 1);
    do_cycle(1, 0, 0, 32'h0, 0);

    // Asynchronous reset during WAIT.
    do_cycle(1, 1, 1, I_LDUR, 0);
    do_cycle(1, 0, 0, 32'h0, 0);
    do_cycle(1, 0, 0, 32'h0, 0);
    do_cycle(1, 0, 0, 32'h0, 0);
    chk("pre_rst_wait", state, 2);
    #2 reset = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_dreq", dmem_req, 0);
    chk("async_illegal", illegal, 0);
    model_reset();
    do_cycle(0, 1, 1, I_ADDI, 0);
    do_cycle(1, 1, 1, I_ADDI, 0);
    chk("post_rst_noreq", imem_req, 0);
    do_cycle(1, 1, 1, I_ADDI, 0);
    chk("post_rst_req", imem_req, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rd;
      case ($urandom_range(0, 6))
        0: rd = I_ADDI;
        1: rd = I_LDUR;
        2: rd = I_ADD;
        3: rd = I_B;
        4: rd = 32'h0;
        default: rd = $urandom;
      endcase
      do_cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
               $urandom_range(0, 1) == 1, rd, ($urandom_range(0, 4) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/legv8_ctrl_sequencer.md
LEGV8_CTRL_SEQUENCER -- requirements
Module: legv8_ctrl_sequencer

Interface
REQ-001 Parameter MAX_EX, default 4: maximum number of execute steps; legal range 1..8.
REQ-002 Parameter EX_LEN_IMM, default 1: execute steps for the DataImm class; legal range 1..MAX_EX.
REQ-003 Parameter EX_LEN_BR, default 1: execute steps for the Branch class; legal range 1..MAX_EX.
REQ-004 Parameter EX_LEN_MEM, default 2: execute steps for the Mem class; legal range 1..MAX_EX.
REQ-005 Parameter EX_LEN_REG, default 1: execute steps for the DataReg class; legal range 1..MAX_EX.
REQ-006 Derived constant STEP_W = max(1, ceil(log2(MAX_EX))).
REQ-007 clock  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 run  in  1  when high, fetches are permitted.
REQ-010 imem_req  out  1  instruction fetch request.
REQ-011 imem_ack  in  1  instruction memory accept; qualifies imem_rdata.
REQ-012 imem_rdata  in  32  fetched instruction.
REQ-013 dmem_req  out  1  data memory access request for the Mem class.
REQ-014 dmem_ack  in  1  data memory completion.
REQ-015 ir  out  32  latched instruction register.
REQ-016 iclass  out  2  decoded class: 0 DataImm, 1 Branch, 2 Mem, 3 DataReg.
REQ-017 state  out  2  current state: 0 IF, 1 EX, 2 WAIT.
REQ-018 ex_step  out  STEP_W  current execute step index.
REQ-019 ex_last  out  1  high in the final execute step.
REQ-020 ir_load  out  1  one-cycle pulse on the fetch handshake.
REQ-021 pc_inc  out  1  one-cycle pulse; identical in timing to ir_load.
REQ-022 illegal  out  1  sticky unallocated-encoding flag.

Function
REQ-023 In IF, imem_req SHALL be high when run=1 or when a request is already outstanding; once raised, it SHALL stay high until imem_ack, regardless of run.
REQ-024 On the cycle where imem_req and imem_ack are both high:
- ir <= imem_rdata; ir_load=1 and pc_inc=1 that cycle;
- the next state is EX with ex_step=0, unless REQ-026 applies.
REQ-025 imem_rdata SHALL be ignored when the handshake is incomplete, and imem_ack SHALL be ignored outside IF.
REQ-026 iclass SHALL be decoded from ir[28:25] as follows:
- sel[1] = ir[27];
- sel[0] = (~ir[27] & ir[26]) | (ir[27] & ir[25]).
REQ-027 Illegal encodings:
- an encoding with imem_rdata[28:26]=000 sets illegal at the handshake;
- the next state is IF, with no EX cycles;
- illegal remains set until reset.
REQ-028 EX: ex_step SHALL increment by one per cycle, from 0 to LEN-1, where LEN is the length for the current class; ex_last = (ex_step == LEN-1).
REQ-029 Non-Mem class, final EX step: the next state is IF and ex_step returns to 0.
REQ-030 Mem class, final EX step:
- dmem_req=1;
- dmem_ack high in the same cycle: next state is IF;
- otherwise: next state is WAIT.
REQ-031 WAIT:
- dmem_req is held at 1, ex_step is frozen at LEN-1, ex_last=1;
- on dmem_ack the next state is IF;
- dmem_ack outside the Mem final step or WAIT SHALL be ignored.
REQ-032 Minimum instruction time is LEN+1 cycles (one IF cycle plus LEN EX cycles); each cycle of memory stall adds one cycle.
REQ-033 The outputs iclass, ex_step, ex_last and state SHALL be registered or decoded from registered state only, and SHALL be glitch-free relative to clock.

Reset
REQ-034 While reset=0:
- state=IF, ir=0, ex_step=0, illegal=0;
- imem_req, dmem_req, ir_load and pc_inc are all 0.
REQ-035 Reset asserted mid-EX or mid-WAIT SHALL abandon the transaction; after release, the first request is a fresh fetch.
REQ-036 The first imem_req SHALL be raised no earlier than the first rising edge after reset deasserts.

Structure
REQ-037 A shared package legv8_ctrl_pkg SHALL hold:
- the state encodings (IF/EX/WAIT);
- the class encodings (DataImm/Branch/Mem/DataReg);
- the illegal-pattern constant.
REQ-038 Class decoding SHALL be a separate combinational sub-module, legv8_iclass_encoder, with input ir[28:25] and output iclass.
REQ-039 The per-class length selection SHALL be a parameter-driven lookup inside legv8_ctrl_sequencer; no dividers and no runtime-programmable lengths.

Verification
REQ-040 Defaults, run=1, imem_ack always 1, imem_rdata=0x91000421 (DataImm) -> pattern IF, EX0, IF; ir_load pulses every 2 cycles; iclass=0.
REQ-041 LDUR 0xF8400020 (Mem), dmem_ack held low for 3 cycles -> IF, EX0, EX1 (dmem_req=1), WAIT, WAIT, WAIT, IF; ex_step=1 throughout WAIT.
REQ-042 imem_ack delayed 4 cycles and run dropped after cycle 1 -> imem_req stays 1 until ack; one ir_load; ir matches imem_rdata.
REQ-043 imem_rdata=0x00000000 -> illegal=1 from the next cycle; no EX state; next fetch proceeds; illegal persists until reset.
REQ-044 reset asserted during WAIT -> dmem_req=0 and state=IF immediately (asynchronously); after release, the first imem_req appears on the first edge.
REQ-045 Parameterisation MAX_EX=8, EX_LEN_REG=8 with ADD 0x8B020020 -> ex_step runs 0..7; ex_last is high only at step 7.
